mem_access_ctrl: RTL and testbench
==================================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter: ADDR_W, default 64, data-bus address width.
REQ-002 clk  in  1  sole clock; all state on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-004 req_valid  in  1  memory-stage request present.
REQ-005 req_ready  out  1  controller accepts request this cycle.
REQ-006 mem_read  in  1  load request.
REQ-007 mem_write  in  1  store request.
REQ-008 load_type  in  3  load width/sign code: 001 lb, 101 lbu, 010 lh, 110 lhu, 011 lw, 111 lwu, 100 ld, 000 none.
REQ-009 store_type  in  3  store width code: 100 sb, 101 sh, 110 sw, 111 sd, 000 none.
REQ-010 addr  in  ADDR_W  byte address of the access.
REQ-011 wdata  in  64  store data, right-aligned.
REQ-012 bus_valid  out  1  bus request valid.
REQ-013 bus_ready  in  1  bus accepts request.
REQ-014 bus_addr  out  ADDR_W  address with bits [2:0] forced to 0.
REQ-015 bus_we  out  1  1 = write.
REQ-016 bus_wdata  out  64  store data shifted to byte lane addr[2:0].
REQ-017 bus_wmask  out  8  byte-enable mask.
REQ-018 bus_rvalid  in  1  bus response valid; read data or write acknowledge.
REQ-019 bus_rdata  in  64  aligned 64-bit read data.
REQ-020 resp_valid  out  1  result available.
REQ-021 resp_ready  in  1  consumer takes result.
REQ-022 resp_data  out  64  extended load result; 0 for stores.
REQ-023 resp_err  out  1  misaligned access, reported with resp_valid.
REQ-024 busy  out  1  high in any state other than IDLE; pipeline stall source.

Function
REQ-025 FSM states: IDLE, REQ, WAIT, RESP.
REQ-026 IDLE: req_ready=1. On req_valid with mem_read^mem_write, latch all request fields.
REQ-027 Aligned request goes to REQ. Misaligned request goes directly to RESP with resp_err=1 and issues no bus transaction.
REQ-028 Misalignment means the address is not a multiple of the access size: h: addr[0]; w: addr[1:0]; d: addr[2:0].
REQ-029 req_valid with neither or both of mem_read/mem_write: not accepted, no state change.
REQ-030 REQ: bus_valid=1 with address, write flag, write data and mask held stable until bus_ready. On bus_ready, go to WAIT.
REQ-031 WAIT: on bus_rvalid, capture the extended result and go to RESP. bus_rvalid in any other state is ignored.
REQ-032 RESP: resp_valid=1 with resp_data and resp_err held stable. On resp_ready, go to IDLE.
REQ-033 Back-to-back requests are not overlapped. A new request is accepted no earlier than the cycle after RESP is exited.
REQ-034 Minimum latency, from acceptance to resp_valid, with bus_ready and bus_rvalid each returned in the first possible cycle: 3 cycles.
REQ-035 Write mask: sb 1 bit, sh 2 bits, sw 4 bits, sd 8'hFF. The mask is shifted left by addr[2:0].
REQ-036 Write data: wdata shifted left by 8*addr[2:0].
REQ-037 Load extraction: bus_rdata shifted right by 8*addr[2:0], then truncated to 8/16/32/64 bits. Signed codes sign-extend to 64 bits; unsigned codes (lbu/lhu/lwu) zero-extend.
REQ-038 Outputs not listed as active in the current state are driven 0.

Reset
REQ-039 rst_n low forces IDLE immediately, including mid-transaction.
REQ-040 During reset: bus_valid=0, resp_valid=0, resp_err=0, busy=0, resp_data=0, all latched fields 0.
REQ-041 After reset, an in-flight bus response is not awaited. A stray bus_rvalid arriving in IDLE is ignored.

Structure
REQ-042 The FSM state encoding belongs in the shared defines file, alongside the existing LOAD_TYPE and STORE_TYPE encodings.
REQ-043 One sub-module, mem_align, is natural: purely combinational mask, write-data shift and load extraction, instantiated once.

Verification
REQ-044 ld addr=0x80000008 with bus_rdata=0x1122334455667788 -> resp_data=0x1122334455667788, resp_err=0, resp_valid 3 cycles after acceptance.
REQ-045 lb addr=0x80000003, bus_rdata=0x00000000_80000000 -> resp_data=0xFFFFFFFFFFFFFF80. Repeat with lbu -> 0x80.
REQ-046 sh addr=0x80000006, wdata=0xABCD -> bus_addr=0x80000000, bus_wmask=8'hC0, bus_wdata=0xABCD000000000000, bus_we=1.
REQ-047 sw addr=0x80000002 -> resp_err=1 one cycle after acceptance, bus_valid never asserted.
REQ-048 bus_ready held low 5 cycles, then rst_n pulsed low in WAIT -> immediate return to IDLE with all outputs 0. The next request completes normally.
REQ-049 resp_ready held low 4 cycles -> resp_valid and resp_data stable throughout, req_ready=0 until RESP exits.

Source files
------------

// File: rtl/mem_access_ctrl_pkg.sv
// Shared encodings for the memory access controller:
// load/store type codes, FSM states and access-size helpers.
package mem_access_ctrl_pkg;

  typedef enum logic [2:0] {
    LT_NONE = 3'b000,
    LT_LB   = 3'b001,
    LT_LH   = 3'b010,
    LT_LW   = 3'b011,
    LT_LD   = 3'b100,
    LT_LBU  = 3'b101,
    LT_LHU  = 3'b110,
    LT_LWU  = 3'b111
  } load_type_e;

  typedef enum logic [2:0] {
    ST_NONE = 3'b000,
    ST_SB   = 3'b100,
    ST_SH   = 3'b101,
    ST_SW   = 3'b110,
    ST_SD   = 3'b111
  } store_type_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_RESP
  } state_e;

  typedef enum logic [1:0] {
    SZ_B,
    SZ_H,
    SZ_W,
    SZ_D
  } size_e;

  function automatic size_e ld_size(
    input logic [2:0] t
  );
    case (t)
      LT_LH, LT_LHU: ld_size = SZ_H;
      LT_LW, LT_LWU: ld_size = SZ_W;
      LT_LD:         ld_size = SZ_D;
      default:       ld_size = SZ_B;
    endcase
  endfunction

  function automatic size_e st_size(
    input logic [2:0] t
  );
    case (t)
      ST_SH:   st_size = SZ_H;
      ST_SW:   st_size = SZ_W;
      ST_SD:   st_size = SZ_D;
      default: st_size = SZ_B;
    endcase
  endfunction

  function automatic logic misaligned(
    input size_e      s,
    input logic [2:0] a
  );
    case (s)
      SZ_H:    misaligned = a[0];
      SZ_W:    misaligned = |a[1:0];
      SZ_D:    misaligned = |a;
      default: misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_align.sv
// Byte-lane alignment: store mask and data shift,
// load extraction with sign or zero extension.
module mem_align (
  input  logic [2:0]  lane,
  input  logic [2:0]  load_type,
  input  logic [2:0]  store_type,
  input  logic [63:0] wdata,
  input  logic [63:0] rdata,
  output logic [7:0]  wmask,
  output logic [63:0] wdata_sh,
  output logic [63:0] load_data
);
  import mem_access_ctrl_pkg::*;

  logic [5:0]  sh_amt;
  logic [7:0]  base;
  logic [63:0] rd_sh;

  assign sh_amt = {lane, 3'b000};

  always_comb begin
    base      = 8'h00;
    load_data = '0;
    case (store_type)
      ST_SB:   base = 8'h01;
      ST_SH:   base = 8'h03;
      ST_SW:   base = 8'h0F;
      ST_SD:   base = 8'hFF;
      default: base = 8'h00;
    endcase
    wmask    = base << lane;
    wdata_sh = wdata << sh_amt;
    rd_sh    = rdata >> sh_amt;
    case (load_type)
      LT_LB:   load_data = {{56{rd_sh[7]}}, rd_sh[7:0]};
      LT_LBU:  load_data = {56'd0, rd_sh[7:0]};
      LT_LH:   load_data = {{48{rd_sh[15]}}, rd_sh[15:0]};
      LT_LHU:  load_data = {48'd0, rd_sh[15:0]};
      LT_LW:   load_data = {{32{rd_sh[31]}}, rd_sh[31:0]};
      LT_LWU:  load_data = {32'd0, rd_sh[31:0]};
      LT_LD:   load_data = rd_sh;
      default: load_data = '0;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-stage access controller: one bus transaction
// at a time, misaligned accesses fault without bus traffic.
module mem_access_ctrl #(
  parameter int ADDR_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [2:0]        load_type,
  input  logic [2:0]        store_type,
  input  logic [ADDR_W-1:0] addr,
  input  logic [63:0]       wdata,
  output logic              bus_valid,
  input  logic              bus_ready,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_we,
  output logic [63:0]       bus_wdata,
  output logic [7:0]        bus_wmask,
  input  logic              bus_rvalid,
  input  logic [63:0]       bus_rdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [63:0]       resp_data,
  output logic              resp_err,
  output logic              busy
);
  import mem_access_ctrl_pkg::*;

  state_e            state, state_nx;
  logic              accept, mis, capture;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [63:0]       lat_wdata;
  logic [2:0]        lat_lt, lat_st;
  logic [63:0]       data_q;
  logic              err_q;
  logic [7:0]        al_mask;
  logic [63:0]       al_wdata, al_load;

  mem_align u_align (
    .lane       (lat_addr[2:0]),
    .load_type  (lat_lt),
    .store_type (lat_st),
    .wdata      (lat_wdata),
    .rdata      (bus_rdata),
    .wmask      (al_mask),
    .wdata_sh   (al_wdata),
    .load_data  (al_load)
  );

  assign mis = mem_read
    ? misaligned(ld_size(load_type), addr[2:0])
    : misaligned(st_size(store_type), addr[2:0]);

  assign capture = (state == S_WAIT) && bus_rvalid;

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (req_valid && (mem_read ^ mem_write)) begin
          accept   = 1'b1;
          state_nx = mis ? S_RESP : S_REQ;
        end
      end
      S_REQ:  if (bus_ready)  state_nx = S_WAIT;
      S_WAIT: if (bus_rvalid) state_nx = S_RESP;
      S_RESP: if (resp_ready) state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_lt    <= '0;
      lat_st    <= '0;
      data_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        lat_we    <= mem_write;
        lat_addr  <= addr;
        lat_wdata <= wdata;
        lat_lt    <= mem_read ? load_type : 3'b000;
        lat_st    <= mem_write ? store_type : 3'b000;
        data_q    <= '0;
        err_q     <= mis;
      end
      // Stores acknowledge with a zero result
      if (capture) data_q <= lat_we ? '0 : al_load;
    end
  end

  always_comb begin
    req_ready  = 1'b0;
    busy       = 1'b1;
    bus_valid  = 1'b0;
    bus_addr   = '0;
    bus_we     = 1'b0;
    bus_wdata  = '0;
    bus_wmask  = '0;
    resp_valid = 1'b0;
    resp_data  = '0;
    resp_err   = 1'b0;
    unique case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
      end
      S_REQ: begin
        bus_valid = 1'b1;
        bus_addr  = {lat_addr[ADDR_W-1:3], 3'b000};
        bus_we    = lat_we;
        bus_wdata = lat_we ? al_wdata : '0;
        bus_wmask = lat_we ? al_mask : '0;
      end
      S_WAIT: ;
      S_RESP: begin
        resp_valid = 1'b1;
        resp_data  = data_q;
        resp_err   = err_q;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized self-checking bench for mem_access_ctrl
// against a byte-level reference model.
module tb_mem_access_ctrl;

  localparam int ADDR_W = 64;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic              mem_read;
  logic              mem_write;
  logic [2:0]        load_type;
  logic [2:0]        store_type;
  logic [ADDR_W-1:0] addr;
  logic [63:0]       wdata;
  logic              bus_valid;
  logic              bus_ready;
  logic [ADDR_W-1:0] bus_addr;
  logic              bus_we;
  logic [63:0]       bus_wdata;
  logic [7:0]        bus_wmask;
  logic              bus_rvalid;
  logic [63:0]       bus_rdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [63:0]       resp_data;
  logic              resp_err;
  logic              busy;

  int vec = 0;
  int miscmp = 0;

  mem_access_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .load_type  (load_type),
    .store_type (store_type),
    .addr       (addr),
    .wdata      (wdata),
    .bus_valid  (bus_valid),
    .bus_ready  (bus_ready),
    .bus_addr   (bus_addr),
    .bus_we     (bus_we),
    .bus_wdata  (bus_wdata),
    .bus_wmask  (bus_wmask),
    .bus_rvalid (bus_rvalid),
    .bus_rdata  (bus_rdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_err   (resp_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int nbytes(
    input logic rd, input logic [2:0] code
  );
    if (rd) begin
      case (code)
        3'b001, 3'b101: return 1;
        3'b010, 3'b110: return 2;
        3'b011, 3'b111: return 4;
        default:        return 8;
      endcase
    end else begin
      case (code)
        3'b100:  return 1;
        3'b101:  return 2;
        3'b110:  return 4;
        default: return 8;
      endcase
    end
  endfunction

  function automatic logic [63:0] exp_load(
    input logic [2:0] code,
    input logic [63:0] rd, input int a
  );
    int n;
    logic [63:0] v;
    logic neg;
    n = nbytes(1'b1, code);
    v = '0;
    for (int i = 0; i < n; i++)
      v[8*i +: 8] = rd[8*(a+i) +: 8];
    neg = v[8*n-1] &&
      (code == 3'b001 || code == 3'b010 ||
       code == 3'b011);
    for (int i = n; i < 8; i++)
      v[8*i +: 8] = neg ? 8'hFF : 8'h00;
    return v;
  endfunction

  function automatic logic [7:0] exp_mask(
    input int n, input int a
  );
    logic [7:0] m;
    m = '0;
    for (int i = 0; i < n; i++) m[a+i] = 1'b1;
    return m;
  endfunction

  // ---------------- stimulus driver ----------------
  task automatic drive_txn(
    input  logic        rd,
    input  logic [2:0]  lt,
    input  logic [2:0]  st,
    input  logic [63:0] a,
    input  logic [63:0] wd,
    input  logic [63:0] rdat,
    input  int          rdy_d,
    input  int          rv_d,
    input  int          rs_d,
    output int          lat,
    output logic        seen,
    output logic        stable,
    output logic        rr_low,
    output logic        to,
    output logic [63:0] b_addr,
    output logic [63:0] b_wdata,
    output logic [63:0] r_data,
    output logic        b_we,
    output logic        r_err,
    output logic [7:0]  b_mask
  );
    int nr, nv, ns;
    @(negedge clk);
    req_valid  = 1'b1;
    mem_read   = rd;
    mem_write  = !rd;
    load_type  = rd ? lt : 3'b000;
    store_type = rd ? 3'b000 : st;
    addr       = a;
    wdata      = wd;
    @(negedge clk);
    req_valid = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    lat = 0; seen = 0; stable = 1;
    rr_low = 1; to = 1;
    b_addr = '0; b_wdata = '0; b_mask = '0;
    b_we = 0; r_data = '0; r_err = 0;
    nr = 0; nv = 0; ns = 0;
    for (int k = 1; k < 100; k++) begin
      bus_ready  = 1'b0;
      bus_rvalid = 1'b0;
      resp_ready = 1'b0;
      bus_rdata  = {$urandom, $urandom};
      if (bus_valid) begin
        if (!seen) begin
          seen = 1; b_addr = bus_addr;
          b_we = bus_we; b_wdata = bus_wdata;
          b_mask = bus_wmask;
        end else if (bus_addr !== b_addr ||
                     bus_we !== b_we ||
                     bus_wdata !== b_wdata ||
                     bus_wmask !== b_mask)
          stable = 0;
        if (nr == rdy_d) bus_ready = 1'b1;
        nr++;
      end else if (busy && !resp_valid) begin
        if (nv == rv_d) begin
          bus_rvalid = 1'b1;
          bus_rdata  = rdat;
        end
        nv++;
      end
      if (resp_valid) begin
        if (lat == 0) begin
          lat = k; r_data = resp_data;
          r_err = resp_err;
        end else if (resp_data !== r_data ||
                     resp_err !== r_err)
          stable = 0;
        if (req_ready !== 1'b0) rr_low = 0;
        if (ns == rs_d) resp_ready = 1'b1;
        ns++;
      end
      @(negedge clk);
      if (resp_ready) begin
        to = 0;
        break;
      end
    end
    bus_ready  = 1'b0;
    bus_rvalid = 1'b0;
    resp_ready = 1'b0;
  endtask

  // ---------------- feature tests ----------------
  int          t_lat;
  logic        t_seen, t_stab, t_rr, t_to;
  logic        t_we, t_err;
  logic [63:0] t_addr, t_wd, t_data;
  logic [7:0]  t_mask;

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    vec++;
    if ({bus_valid, resp_valid, resp_err, busy}
        !== 4'b0000) begin
      miscmp++;
      $display("FAIL reset_ctrl got %b want 0000",
        {bus_valid, resp_valid, resp_err, busy});
    end
    vec++;
    if (resp_data !== 64'd0) begin
      miscmp++;
      $display("FAIL reset_data got %h want 0",
        resp_data);
    end
    vec++;
    if (req_ready !== 1'b1) begin
      miscmp++;
      $display("FAIL reset_rdy got %b want 1",
        req_ready);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_ld();
    drive_txn(1'b1, 3'b100, 3'b000,
      64'h8000_0008, 64'd0,
      64'h1122334455667788, 0, 0, 0,
      t_lat, t_seen, t_stab, t_rr, t_to,
      t_addr, t_wd, t_data, t_we, t_err, t_mask);
    vec++;
    if (t_to || t_data !== 64'h1122334455667788
        || t_err !== 1'b0) begin
      miscmp++;
      $display("FAIL ld_data got %h err %b want %h",
        t_data, t_err, 64'h1122334455667788);
    end
    vec++;
    if (t_lat != 3) begin
      miscmp++;
      $display("FAIL ld_latency got %0d want 3",
        t_lat);
    end
    vec++;
    if (t_addr !== 64'h8000_0008 || t_we !== 1'b0)
    begin
      miscmp++;
      $display("FAIL ld_bus got %h we %b want %h",
        t_addr, t_we, 64'h8000_0008);
    end
  endtask

  task automatic test_lb();
    drive_txn(1'b1, 3'b001, 3'b000,
      64'h8000_0003, 64'd0,
      64'h0000_0000_8000_0000, 0, 0, 0,
      t_lat, t_seen, t_stab, t_rr, t_to,
      t_addr, t_wd, t_data, t_we, t_err, t_mask);
    vec++;
    if (t_to || t_data !== 64'hFFFF_FFFF_FFFF_FF80)
    begin
      miscmp++;
      $display("FAIL lb_sext got %h want %h",
        t_data, 64'hFFFF_FFFF_FFFF_FF80);
    end
    drive_txn(1'b1, 3'b101, 3'b000,
      64'h8000_0003, 64'd0,
      64'h0000_0000_8000_0000, 0, 0, 0,
      t_lat, t_seen, t_stab, t_rr, t_to,
      t_addr, t_wd, t_data, t_we, t_err, t_mask);
    vec++;
    if (t_to || t_data !== 64'h80) begin
      miscmp++;
      $display("FAIL lbu_zext got %h want 80",
        t_data);
    end
  endtask

  task automatic test_sh();
    drive_txn(1'b0, 3'b000, 3'b101,
      64'h8000_0006, 64'hABCD, 64'd0, 0, 0, 0,
      t_lat, t_seen, t_stab, t_rr, t_to,
      t_addr, t_wd, t_data, t_we, t_err, t_mask);
    vec++;
    if (t_addr !== 64'h8000_0000 || t_we !== 1'b1)
    begin
      miscmp++;
      $display("FAIL sh_addr got %h we %b want %h",
        t_addr, t_we, 64'h8000_0000);
    end
    vec++;
    if (t_mask !== 8'hC0) begin
      miscmp++;
      $display("FAIL sh_mask got %h want c0",
        t_mask);
    end
    vec++;
    if (t_wd !== 64'hABCD_0000_0000_0000) begin
      miscmp++;
      $display("FAIL sh_wdata got %h want %h",
        t_wd, 64'hABCD_0000_0000_0000);
    end
    vec++;
    if (t_to || t_data !== 64'd0 || t_err !== 1'b0)
    begin
      miscmp++;
      $display("FAIL sh_resp got %h err %b want 0",
        t_data, t_err);
    end
  endtask

  task automatic test_misaligned();
    drive_txn(1'b0, 3'b000, 3'b110,
      64'h8000_0002, 64'h1234, 64'd0, 0, 0, 0,
      t_lat, t_seen, t_stab, t_rr, t_to,
      t_addr, t_wd, t_data, t_we, t_err, t_mask);
    vec++;
    if (t_to || t_err !== 1'b1 || t_lat != 1) begin
      miscmp++;
      $display("FAIL sw_mis got err %b lat %0d want 1/1",
        t_err, t_lat);
    end
    vec++;
    if (t_seen !== 1'b0) begin
      miscmp++;
      $display("FAIL sw_mis_bus got %b want 0",
        t_seen);
    end
  endtask

  task automatic test_illegal();
    @(negedge clk);
    req_valid = 1'b1;
    mem_read  = 1'b1;
    mem_write = 1'b1;
    load_type = 3'b100;
    addr      = 64'h8000_0000;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 2) begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
      end
      vec++;
      if (busy !== 1'b0 || req_ready !== 1'b1) begin
        miscmp++;
        $display("FAIL illegal_req got busy %b rdy %b want 0/1",
          busy, req_ready);
      end
    end
    req_valid = 1'b0;
    load_type = 3'b000;
  endtask

  task automatic test_reset_mid();
    logic held;
    @(negedge clk);
    req_valid = 1'b1;
    mem_read  = 1'b1;
    load_type = 3'b100;
    addr      = 64'h8000_0010;
    @(negedge clk);
    req_valid = 1'b0;
    mem_read  = 1'b0;
    held = 1'b1;
    bus_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (bus_valid !== 1'b1) held = 1'b0;
      @(negedge clk);
    end
    vec++;
    if (!held) begin
      miscmp++;
      $display("FAIL hold_req got drop want held");
    end
    bus_ready = 1'b1;
    @(negedge clk);
    bus_ready = 1'b0;
    vec++;
    if ({busy, bus_valid, resp_valid} !== 3'b100)
    begin
      miscmp++;
      $display("FAIL wait_state got %b want 100",
        {busy, bus_valid, resp_valid});
    end
    #1 rst_n = 1'b0;
    #1;
    vec++;
    if ({bus_valid, bus_we, resp_valid, resp_err,
         busy} !== 5'd0 || bus_addr !== '0 ||
        bus_wdata !== '0 || bus_wmask !== '0 ||
        resp_data !== '0) begin
      miscmp++;
      $display("FAIL async_rst got busy %b bv %b rv %b want 0",
        busy, bus_valid, resp_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus_rvalid = 1'b1;
    bus_rdata  = 64'hFFFF_FFFF_FFFF_FFFF;
    repeat (2) @(negedge clk);
    bus_rvalid = 1'b0;
    vec++;
    if (busy !== 1'b0 || resp_valid !== 1'b0) begin
      miscmp++;
      $display("FAIL stray_rvalid got busy %b rv %b want 0/0",
        busy, resp_valid);
    end
    drive_txn(1'b1, 3'b011, 3'b000,
      64'h8000_0004, 64'd0,
      64'hDEAD_BEEF_0000_0000, 0, 0, 0,
      t_lat, t_seen, t_stab, t_rr, t_to,
      t_addr, t_wd, t_data, t_we, t_err, t_mask);
    vec++;
    if (t_to || t_data !== 64'hFFFF_FFFF_DEAD_BEEF
        || t_lat != 3) begin
      miscmp++;
      $display("FAIL post_rst_lw got %h lat %0d want %h/3",
        t_data, t_lat, 64'hFFFF_FFFF_DEAD_BEEF);
    end
  endtask

  task automatic test_resp_stall();
    drive_txn(1'b1, 3'b110, 3'b000,
      64'h8000_0002, 64'd0,
      64'h0000_0000_9876_0000, 0, 0, 4,
      t_lat, t_seen, t_stab, t_rr, t_to,
      t_addr, t_wd, t_data, t_we, t_err, t_mask);
    vec++;
    if (t_to || t_data !== 64'h9876 || !t_stab) begin
      miscmp++;
      $display("FAIL stall_data got %h stable %b want 9876/1",
        t_data, t_stab);
    end
    vec++;
    if (!t_rr) begin
      miscmp++;
      $display("FAIL stall_rdy got high want 0");
    end
    vec++;
    if (req_ready !== 1'b1) begin
      miscmp++;
      $display("FAIL stall_exit got %b want 1",
        req_ready);
    end
  endtask

  task automatic test_random();
    logic [2:0] lcodes [7];
    logic [2:0] scodes [4];
    lcodes = '{3'b001, 3'b101, 3'b010, 3'b110,
               3'b011, 3'b111, 3'b100};
    scodes = '{3'b100, 3'b101, 3'b110, 3'b111};
    for (int it = 0; it < 60; it++) begin
      logic rd, mis;
      logic [2:0] lt, st, code;
      logic [63:0] a, wd, rdat, e_data;
      int n, lane, rdy_d, rv_d, e_lat;
      rd = 1'($urandom_range(0, 1));
      lt = lcodes[$urandom_range(0, 6)];
      st = scodes[$urandom_range(0, 3)];
      code = rd ? lt : st;
      n = nbytes(rd, code);
      if ($urandom_range(0, 2) != 0)
        lane = $urandom_range(0, 8/n - 1) * n;
      else
        lane = $urandom_range(0, 7);
      a = {$urandom, $urandom};
      a[2:0] = 3'(lane);
      wd = {$urandom, $urandom};
      rdat = {$urandom, $urandom};
      rdy_d = $urandom_range(0, 3);
      rv_d = $urandom_range(0, 3);
      mis = (lane % n) != 0;
      e_lat = mis ? 1 : 3 + rdy_d + rv_d;
      e_data = (rd && !mis) ?
        exp_load(lt, rdat, lane) : 64'd0;
      drive_txn(rd, lt, st, a, wd, rdat,
        rdy_d, rv_d, $urandom_range(0, 2),
        t_lat, t_seen, t_stab, t_rr, t_to,
        t_addr, t_wd, t_data, t_we, t_err, t_mask);
      vec++;
      if (t_to || t_err !== mis ||
          t_data !== e_data) begin
        miscmp++;
        $display("FAIL rnd%0d_resp got %h err %b want %h err %b",
          it, t_data, t_err, e_data, mis);
      end
      vec++;
      if (t_lat != e_lat || t_seen !== !mis) begin
        miscmp++;
        $display("FAIL rnd%0d_lat got %0d bus %b want %0d",
          it, t_lat, t_seen, e_lat);
      end
      if (!mis) begin
        vec++;
        if (t_addr !== {a[63:3], 3'b000} ||
            t_we !== !rd || !t_stab) begin
          miscmp++;
          $display("FAIL rnd%0d_bus got %h we %b want %h",
            it, t_addr, t_we, {a[63:3], 3'b000});
        end
        if (!rd) begin
          vec++;
          if (t_mask !== exp_mask(n, lane) ||
              t_wd !== (wd << (8*lane))) begin
            miscmp++;
            $display("FAIL rnd%0d_wr got %h/%h want %h/%h",
              it, t_mask, t_wd, exp_mask(n, lane),
              wd << (8*lane));
          end
        end
      end
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    load_type  = 3'b000;
    store_type = 3'b000;
    addr       = '0;
    wdata      = '0;
    bus_ready  = 1'b0;
    bus_rvalid = 1'b0;
    bus_rdata  = '0;
    resp_ready = 1'b0;
    test_reset();
    test_ld();
    test_lb();
    test_sh();
    test_misaligned();
    test_illegal();
    test_reset_mid();
    test_resp_stall();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
      vec, miscmp);
    $finish;
  end

endmodule
